// File: rtl/mod_pkg.sv
// Shared types and helpers for the shared sequential modulo unit.
package mod_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} mod_state_t;

   localparam int MOD_WIDTH = 4;
   localparam int MOD_NREQ  = 2;
   localparam int MAX_NREQ  = 32;

   // Round-robin search: first requester after 'last', wrapping, among nreq lanes.
   function automatic int rr_next(input logic [MAX_NREQ-1:0] req, input int nreq, input int last);
      int  pick;
      int  idx;
      bit  found;
      pick  = last;
      found = 1'b0;
      for (int i = 1; i <= MAX_NREQ; i++) begin
         if (i <= nreq && !found) begin
            idx = last + i;
            if (idx >= nreq) idx = idx - nreq;
            if (req[idx[4:0]]) begin
               pick  = idx;
               found = 1'b1;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/mod_if.sv
// Requester-side bus of the modulo arbiter: per-client requests/operands and shared results.
interface mod_if import mod_pkg::*; #(
   parameter int WIDTH = MOD_WIDTH,
   parameter int NREQ  = MOD_NREQ
);
   logic [NREQ-1:0]             req_i;
   logic [NREQ-1:0][WIDTH-1:0]  a_i;
   logic [NREQ-1:0][WIDTH-1:0]  b_i;
   logic [NREQ-1:0]             gnt_o;
   logic [NREQ-1:0]             done_o;
   logic [WIDTH-1:0]            c_o;
   logic                        err_o;
   logic                        busy_o;

   modport master (
      output req_i, a_i, b_i,
      input  gnt_o, done_o, c_o, err_o, busy_o
   );

   modport slave (
      input  req_i, a_i, b_i,
      output gnt_o, done_o, c_o, err_o, busy_o
   );
endinterface

// File: rtl/mod_seq_core.sv
// Restoring shift-subtract remainder engine: one step per enabled cycle, WIDTH steps per operand.
module mod_seq_core import mod_pkg::*; #(
   parameter int WIDTH = MOD_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] rem,
   output logic             last_step,
   output logic             div_zero
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] b_q;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   r_sh;
   logic [WIDTH-1:0] r_nxt;

   // After a subtract the partial remainder is below b, so WIDTH bits suffice to store it.
   always_comb begin
      r_sh = {r, q[WIDTH-1]};
      if (r_sh >= {1'b0, b_q}) r_nxt = WIDTH'(r_sh - {1'b0, b_q});
      else                     r_nxt = r_sh[WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r   <= '0;
         q   <= '0;
         b_q <= '0;
         cnt <= '0;
      end else if (load) begin
         r   <= '0;
         q   <= a;
         b_q <= b;
         cnt <= CW'(WIDTH - 1);
      end else if (en) begin
         r <= r_nxt;
         q <= q << 1;
         if (cnt != '0) cnt <= cnt - 1'b1;
      end
   end

   // rem is the value the step in progress produces; it is final when last_step is high.
   assign rem       = r_nxt;
   assign last_step = en && (cnt == '0);
   assign div_zero  = (b_q == '0);

endmodule

// File: rtl/mod_arbiter.sv
// Round-robin front end sharing one sequential modulo engine among NREQ requesters.
//
// state | meaning
// IDLE  | waiting for any request; accepts one round-robin and loads the engine
// CALC  | engine runs one restoring step per cycle for WIDTH cycles
// DONE  | one-cycle done pulse to the granted requester with remainder and error
module mod_arbiter import mod_pkg::*; #(
   parameter int WIDTH = MOD_WIDTH,
   parameter int NREQ  = MOD_NREQ
) (
   input  logic clk,
   input  logic rst_n,
   mod_if.slave bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   mod_state_t       state;
   logic [IW-1:0]    ptr;
   logic [IW-1:0]    pick;
   logic [WIDTH-1:0] a_sel;
   logic [WIDTH-1:0] b_sel;
   logic             load;
   logic             en;
   logic [WIDTH-1:0] rem;
   logic             last_step;
   logic             div_zero;

   logic [NREQ-1:0]  gnt_q;
   logic [NREQ-1:0]  done_q;
   logic [WIDTH-1:0] c_q;
   logic             err_q;
   logic             busy_q;

   always_comb begin
      pick  = IW'(rr_next(MAX_NREQ'(bus.req_i), NREQ, int'(ptr)));
      a_sel = bus.a_i[pick];
      b_sel = bus.b_i[pick];
   end

   assign load = (state == IDLE) && (|bus.req_i);
   assign en   = (state == CALC);

   mod_seq_core #(.WIDTH(WIDTH)) u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .en        (en),
      .a         (a_sel),
      .b         (b_sel),
      .rem       (rem),
      .last_step (last_step),
      .div_zero  (div_zero)
   );

   // Pointer resets to the last lane so the first search starts at requester 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         ptr    <= IW'(NREQ - 1);
         gnt_q  <= '0;
         done_q <= '0;
         c_q    <= '0;
         err_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|bus.req_i) begin
                  gnt_q  <= NREQ'(1) << pick;
                  ptr    <= pick;
                  busy_q <= 1'b1;
                  state  <= CALC;
               end
            end
            CALC: begin
               if (last_step) begin
                  done_q <= gnt_q;
                  c_q    <= rem;
                  err_q  <= div_zero;
                  state  <= DONE;
               end
            end
            DONE: begin
               done_q <= '0;
               err_q  <= 1'b0;
               gnt_q  <= '0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.gnt_o  = gnt_q;
   assign bus.done_o = done_q;
   assign bus.c_o    = c_q;
   assign bus.err_o  = err_q;
   assign bus.busy_o = busy_q;

endmodule

// File: tb/tb_mod_arbiter.sv
// Self-checking bench for mod_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_mod_arbiter;
   import mod_pkg::*;

   localparam int W = 4;
   localparam int N = 2;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   errors;

   int   left [N];
   int   pa   [N];
   int   pb   [N];
   int   last_g;
   int   gseq [$];
   int   accq [$];

   mod_if #(.WIDTH(W), .NREQ(N)) bus ();

   mod_arbiter #(.WIDTH(W), .NREQ(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_op(input int r, input int a, input int b);
      pa[r] = a;
      pb[r] = b;
      bus.a_i[r] = W'(a);
      bus.b_i[r] = W'(b);
   endtask

   function automatic int rnd_b();
      if ($urandom_range(0, 4) == 0) return 0;
      return int'($urandom_range(1, 15));
   endfunction

   function automatic int model_pick();
      for (int i = 1; i <= N; i++) begin
         int k;
         k = (last_g + i) % N;
         if (left[k] > 0) return k;
      end
      return -1;
   endfunction

   task automatic drive_req();
      for (int i = 0; i < N; i++) bus.req_i[i] = (left[i] > 0);
   endtask

   // Serves all outstanding ops in left[]; called and returns at a negedge.
   task automatic serve(input bit scramble);
      bit in_op;
      bit chk_idle;
      int cur;
      int acc;
      int exp_c;
      int exp_e;
      in_op    = 0;
      chk_idle = 0;
      cur      = 0;
      acc      = 0;
      exp_c    = 0;
      exp_e    = 0;
      gseq.delete();
      accq.delete();
      drive_req();
      for (int t = 0; t < 400 && ((left[0] + left[1]) > 0 || in_op || chk_idle); t++) begin
         @(posedge clk);
         @(negedge clk);
         if (chk_idle) begin
            check("idle_after_done", {30'd0, bus.busy_o, bus.err_o}, 32'd0);
            check("idle_gnt", 32'(bus.gnt_o), 32'd0);
            chk_idle = 0;
         end else if (!in_op) begin
            if (bus.gnt_o != '0) begin
               cur = model_pick();
               check("grant", 32'(bus.gnt_o), (cur < 0) ? 32'd0 : (32'd1 << cur));
               check("busy_on_accept", 32'(bus.busy_o), 32'd1);
               if (cur < 0) cur = 0;
               in_op = 1;
               acc   = cyc;
               exp_c = (pb[cur] == 0) ? pa[cur] : pa[cur] % pb[cur];
               exp_e = (pb[cur] == 0) ? 1 : 0;
               gseq.push_back(cur);
               accq.push_back(cyc);
            end
            check("done_while_idle", 32'(bus.done_o), 32'd0);
         end else if (bus.done_o != '0) begin
            check("done_onehot", 32'(bus.done_o), 32'd1 << cur);
            check("gnt_held", 32'(bus.gnt_o), 32'd1 << cur);
            check("latency", 32'(cyc - acc), 32'(W));
            check("remainder", 32'(bus.c_o), 32'(exp_c));
            check("div_zero_flag", 32'(bus.err_o), 32'(exp_e));
            last_g = cur;
            in_op  = 0;
            left[cur]--;
            if (left[cur] > 0) load_op(cur, int'($urandom_range(0, 15)), rnd_b());
            chk_idle = 1;
         end else if (scramble) begin
            bus.a_i[cur] = W'($urandom);
            bus.b_i[cur] = W'($urandom);
         end
         drive_req();
      end
      check("serve_complete", {30'd0, in_op, ((left[0] + left[1]) > 0)}, 32'd0);
      for (int i = 0; i < N; i++) left[i] = 0;
      drive_req();
   endtask

   initial begin
      int a_tab [4];
      int b_tab [4];
      bit seen;
      cyc    = 0;
      checks = 0;
      errors = 0;
      last_g = N - 1;
      rst_n  = 1'b0;
      bus.req_i = '0;
      bus.a_i   = '0;
      bus.b_i   = '0;
      for (int i = 0; i < N; i++) begin
         left[i] = 0;
         pa[i]   = 0;
         pb[i]   = 0;
      end
      #1;
      check("reset_outputs", {19'd0, bus.gnt_o, bus.done_o, bus.c_o, bus.err_o, bus.busy_o}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Contention from reset: requester 0 first, requester 1 accepted six cycles later.
      left[0] = 1; left[1] = 1;
      load_op(0, 13, 10);
      load_op(1, 9, 2);
      serve(0);
      check("cont_first", (gseq.size() > 0) ? 32'(gseq[0]) : 32'hffff, 32'd0);
      check("cont_second", (gseq.size() > 1) ? 32'(gseq[1]) : 32'hffff, 32'd1);
      check("cont_spacing", (accq.size() > 1) ? 32'(accq[1] - accq[0]) : 32'hffff, 32'(W + 2));

      // Fairness: both keep requesting, grants must alternate.
      left[0] = 3; left[1] = 3;
      load_op(0, int'($urandom_range(0, 15)), rnd_b());
      load_op(1, int'($urandom_range(0, 15)), rnd_b());
      serve(0);
      check("fair_count", 32'(gseq.size()), 32'd6);
      for (int i = 0; i < gseq.size(); i++) check("fair_order", 32'(gseq[i]), 32'(i % 2));

      // Directed single ops on requester 0.
      a_tab = '{13, 8, 9, 15};
      b_tab = '{10, 3, 2, 6};
      for (int i = 0; i < 4; i++) begin
         left[0] = 1;
         load_op(0, a_tab[i], b_tab[i]);
         serve(0);
      end

      left[0] = 1;
      load_op(0, 7, 0);
      serve(0);

      // Operands scrambled during CALC must not affect the result.
      left[0] = 1;
      load_op(0, 13, 10);
      serve(1);

      // Reset in the middle of CALC abandons the operation.
      left[0] = 1;
      load_op(0, 13, 10);
      drive_req();
      seen = 0;
      for (int t = 0; t < 10 && !seen; t++) begin
         @(negedge clk);
         if (bus.gnt_o != '0) seen = 1;
      end
      check("rst_pre_grant", 32'(bus.gnt_o), 32'd1);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_clear", {19'd0, bus.gnt_o, bus.done_o, bus.c_o, bus.err_o, bus.busy_o}, 32'd0);
      left[0] = 0;
      drive_req();
      @(negedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      last_g = N - 1;
      seen   = 0;
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         if (bus.done_o != '0 || bus.busy_o) seen = 1;
      end
      check("rst_no_done", 32'(seen), 32'd0);
      left[0] = 1;
      load_op(0, 13, 10);
      serve(0);
      check("rst_regrant", (gseq.size() > 0) ? 32'(gseq[0]) : 32'hffff, 32'd0);

      // Randomized traffic with operand scrambling.
      for (int r = 0; r < 8; r++) begin
         left[0] = int'($urandom_range(0, 3));
         left[1] = int'($urandom_range(0, 3));
         if (left[0] + left[1] == 0) left[1] = 1;
         load_op(0, int'($urandom_range(0, 15)), rnd_b());
         load_op(1, int'($urandom_range(0, 15)), rnd_b());
         serve(r[0]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mod_arbiter.md
# mod_arbiter

Shared sequential modulo unit with a round-robin arbiter. It serves NREQ requesters through one shared engine that computes c = a mod b by restoring shift-subtract over WIDTH cycles, and it replaces one combinational modulo instance per client. Each request gets a grant, then a one-cycle done pulse carrying the remainder and a divide-by-zero flag. The block sits between the lab's operand sources (switch/FSM clients) and the result display path.

## Interface
Parameters:
- WIDTH, 4: operand and result width.
- NREQ, 2: number of requesters (≥2).

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- req_i, input, NREQ: level request, one bit per requester.
- a_i, input, NREQ×WIDTH: dividend per requester (packed array).
- b_i, input, NREQ×WIDTH: divisor per requester (packed array).
- gnt_o, output, NREQ: one-hot grant, held from acceptance through the done cycle.
- done_o, output, NREQ: one-hot, single-cycle completion pulse.
- c_o, output, WIDTH: remainder. Valid during the done cycle; holds the last value otherwise.
- err_o, output, 1: b was 0. Valid only with done; 0 otherwise.
- busy_o, output, 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If any req_i bit is high at a rising edge, grant one requester round-robin, starting the search at the index after the last granted one.
  - Latch that requester's a_i and b_i, set gnt_o, clear the step counter, go to CALC.
  - If no request is high, stay in IDLE.
- CALC: one restoring step per edge.
  - R = {R, next a bit MSB-first}; if R ≥ b then R -= b.
  - R is WIDTH+1 bits.
  - After WIDTH steps, go to DONE.
- DONE:
  - done_o[gnt] = 1, c_o = R[WIDTH-1:0].
  - err_o = 1 if the latched b == 0.
  - Next edge: go to IDLE and clear gnt_o.
- b == 0: still runs the full WIDTH steps for fixed latency. c_o = a and err_o = 1.
- Operands are captured only at acceptance. Later changes to a_i, b_i, or req_i of any requester are ignored until IDLE.
- Round-robin pointer:
  - Reset value makes requester 0 highest priority.
  - Updated only on acceptance.
  - A requester that keeps req_i high loses priority to any other pending requester.
- Requester protocol: hold req_i and operands until done_o. Drop req_i by the edge that ends the done cycle, or it is treated as a new request.

## Timing
- Acceptance edge E. CALC steps happen on edges E+1 … E+WIDTH. done_o is high for the cycle between edges E+WIDTH and E+WIDTH+1.
- Latency from acceptance to done is WIDTH cycles. For WIDTH=4, that is 4.
- Earliest next acceptance is E+WIDTH+2, so throughput is 1 op per WIDTH+2 cycles.
- Simultaneous requests: exactly one grant per acceptance. The others wait, with no loss and no starvation; worst case is NREQ-1 full ops.
- Reset (asynchronous, any state):
  - state = IDLE; gnt_o, done_o, c_o, err_o, busy_o = 0.
  - Pointer resets; engine registers clear.
- Reset mid-operation: the in-flight op is abandoned, no done_o is issued, and the requester must re-request.
- No combinational path from req_i, a_i, or b_i to any output. All outputs are registered or decoded from state.

## Structure
- Package mod_pkg holds:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} mod_state_t
  - the default WIDTH constant
  - a function returning the next round-robin index
- Sub-module mod_seq_core contains:
  - inputs: load, a, b
  - one step per cycle while enabled
  - outputs: rem, last_step, div_zero
- mod_arbiter contains the FSM, the round-robin pointer, operand muxing, and output registers.

## Test plan
- Reset: assert rst_n=0 mid-CALC. All outputs go to 0 immediately, with no done afterward. Release reset, then req_i=01 with 13,10: grant to requester 0.
- Single ops on requester 0, one at a time, WIDTH=4:
  - 1101 mod 1010 gives c=0011.
  - 1000 mod 0011 gives 0010.
  - 1001 mod 0010 gives 0001.
  - 1111 mod 0110 gives 0011.
  - Each done comes exactly 4 cycles after acceptance.
- Contention: req_i=11 in the same cycle, requester 0 with (13,10), requester 1 with (9,2).
  - Requester 0 is served first: c=3.
  - Requester 1 is accepted at E+6: c=1, done on done_o[1] only.
- Fairness: both requesters hold req_i high for 6 ops. Grants alternate 0,1,0,1,0,1.
- Divide by zero: a=0111, b=0000. done with err_o=1 and c_o=0111, same latency as any other op.
- Operand stability: change a_i and b_i during CALC. c_o still reflects the values latched at acceptance.
